ccff_chain_loader: RTL and testbench

- Programming-side controller that sequences the fabric configuration chain (ccff_head → tiles → ccff_tail).
- Accepts bitstream words over a valid/ready interface and serializes them MSB-first onto ccff_head, one bit per enabled prog_clk cycle, for exactly CHAIN_LEN bits.
- While loading, it captures the previous chain contents emerging at ccff_tail and returns them as readback words.
- Sits between the bitstream source (SPI/JTAG bridge) and the fabric chain; drives the shift-enable that gates prog_clk to the tiles.

---
 rtl/ccff_chain_loader.sv | 247 ++++++++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Programming-side controller for the fabric configuration chain
// (ccff_head -> tiles -> ccff_tail). Bitstream words arrive over a
// valid/ready interface and are serialized MSB-first onto o_ccff_head, one
// bit per enabled prog_clk cycle, for exactly CHAIN_LEN bits. The previous
// chain contents emerging at i_ccff_tail are captured and returned as
// readback words (first captured bit in the MSB).
//
// Ports:
//   i_prog_clk   programming clock (rising edge)
//   i_pReset_n   asynchronous active-low reset
//   i_start      1-cycle request to begin a full chain load (IDLE only)
//   i_abort      cancels an in-progress load (LOAD/DRAIN only, beats start)
//   i_cfg_data   bitstream word, MSB shifted first
//   i_cfg_valid  i_cfg_data valid
//   o_cfg_ready  word accepted when i_cfg_valid & o_cfg_ready
//   o_ccff_head  serial bit into the chain
//   o_ccff_en    chain shift enable (clock-gate enable for the tiles)
//   i_ccff_tail  serial bit out of the chain
//   o_rd_data    readback word, held until the next o_rd_valid pulse
//   o_rd_valid   1-cycle pulse qualifying o_rd_data
//   o_busy       high while loading or draining
//   o_done       1-cycle pulse on successful completion
//   o_aborted    1-cycle pulse when an abort is taken
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              i_prog_clk,
  input  logic              i_pReset_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [WORD_W-1:0] i_cfg_data,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  output logic              o_ccff_head,
  output logic              o_ccff_en,
  input  logic              i_ccff_tail,
  output logic [WORD_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int CAP_W = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] LP_CHAIN = CNT_W'(CHAIN_LEN);
  // Largest number of bits a single word can contribute, in counter width.
  localparam logic [CNT_W-1:0] LP_WCAP  = (WORD_W >= CHAIN_LEN) ? CNT_W'(CHAIN_LEN)
                                                                : CNT_W'(WORD_W);
  localparam logic [CAP_W-1:0] LP_WW    = CAP_W'(WORD_W);

  logic [1:0]        r_state;
  logic [WORD_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_pend;      // bits of r_shift still to be issued
  logic [CNT_W-1:0]  r_bits;      // bits issued so far this load
  logic              r_cfg_ready;
  logic              r_ccff_head;
  logic              r_ccff_en;
  logic [WORD_W-1:0] r_cap;
  logic [CAP_W-1:0]  r_cap_cnt;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;

  logic              w_issue;
  logic [CNT_W-1:0]  w_bits_after;
  logic [CNT_W-1:0]  w_remain;
  logic [CNT_W-1:0]  w_load_cnt;
  logic              w_abort_take;

  logic [1:0]        w_state_next;
  logic [WORD_W-1:0] w_shift_next;
  logic [CNT_W-1:0]  w_pend_next;
  logic [CNT_W-1:0]  w_bits_next;
  logic              w_head_next;
  logic              w_en_next;
  logic              w_ready_next;
  logic              w_busy_next;
  logic              w_done_next;
  logic              w_aborted_next;

  logic [WORD_W-1:0] w_cap_shift;
  logic [CAP_W-1:0]  w_cap_inc;
  logic [WORD_W-1:0] w_cap_next;
  logic [CAP_W-1:0]  w_cap_cnt_next;
  logic [WORD_W-1:0] w_rd_data_next;
  logic              w_rd_valid_next;

  assign w_issue      = (r_pend != '0);
  assign w_bits_after = r_bits + CNT_W'(w_issue);
  // A word is only accepted when at most one bit is pending, and that bit is
  // issued in the same cycle, so the new word starts from w_bits_after.
  assign w_remain     = LP_CHAIN - w_bits_after;
  assign w_load_cnt   = (w_remain > LP_WCAP) ? LP_WCAP : w_remain;
  assign w_abort_take = i_abort && ((r_state == ST_LOAD) || (r_state == ST_DRAIN));

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_pend_next    = r_pend;
    w_bits_next    = r_bits;
    w_head_next    = r_ccff_head;
    w_en_next      = 1'b0;
    w_done_next    = 1'b0;
    w_aborted_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          w_state_next = ST_LOAD;
          w_shift_next = '0;
          w_pend_next  = '0;
          w_bits_next  = '0;
        end
      end
      ST_LOAD: begin
        if (i_abort) begin
          w_state_next   = ST_IDLE;
          w_aborted_next = 1'b1;
          w_shift_next   = '0;
          w_pend_next    = '0;
        end else begin
          // Without a pending bit the chain simply stalls: en low, head held.
          if (w_issue) begin
            w_head_next  = r_shift[WORD_W-1];
            w_en_next    = 1'b1;
            w_shift_next = r_shift << 1;
            w_pend_next  = r_pend - CNT_W'(1);
            w_bits_next  = w_bits_after;
          end
          if (r_cfg_ready && i_cfg_valid) begin
            w_shift_next = i_cfg_data;
            w_pend_next  = w_load_cnt;
          end
          if (w_bits_next == LP_CHAIN) begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (i_abort) begin
          w_state_next   = ST_IDLE;
          w_aborted_next = 1'b1;
        end else begin
          w_state_next = ST_DONE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    // Ready is raised one cycle ahead so the next word lands in the same
    // cycle the last pending bit goes out (zero-bubble streaming).
    w_ready_next = (w_state_next == ST_LOAD) && (w_pend_next <= CNT_W'(1)) &&
                   ((w_bits_next + w_pend_next) != LP_CHAIN);
    w_busy_next  = (w_state_next == ST_LOAD) || (w_state_next == ST_DRAIN);
  end

  // Readback: the tail bit shifts out on every edge that ends a cycle with
  // the registered enable high, so it is sampled on exactly those edges.
  assign w_cap_shift = (r_cap << 1) | WORD_W'(i_ccff_tail);
  assign w_cap_inc   = r_cap_cnt + CAP_W'(1);

  always_comb begin
    w_cap_next      = r_cap;
    w_cap_cnt_next  = r_cap_cnt;
    w_rd_data_next  = r_rd_data;
    w_rd_valid_next = 1'b0;
    if (((r_state == ST_IDLE) && i_start && !i_abort) || w_abort_take) begin
      w_cap_next     = '0;
      w_cap_cnt_next = '0;
    end else if (r_ccff_en) begin
      if (w_cap_inc == LP_WW) begin
        w_rd_valid_next = 1'b1;
        w_rd_data_next  = w_cap_shift;
        w_cap_next      = '0;
        w_cap_cnt_next  = '0;
      end else if (r_state == ST_DRAIN) begin
        // Final partial word: left-justify so unused LSBs read as zero.
        w_rd_valid_next = 1'b1;
        w_rd_data_next  = w_cap_shift << (LP_WW - w_cap_inc);
        w_cap_next      = '0;
        w_cap_cnt_next  = '0;
      end else begin
        w_cap_next     = w_cap_shift;
        w_cap_cnt_next = w_cap_inc;
      end
    end
  end

  always_ff @(posedge i_prog_clk or negedge i_pReset_n) begin
    if (!i_pReset_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_pend      <= '0;
      r_bits      <= '0;
      r_cfg_ready <= 1'b0;
      r_ccff_head <= 1'b0;
      r_ccff_en   <= 1'b0;
      r_cap       <= '0;
      r_cap_cnt   <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_pend      <= w_pend_next;
      r_bits      <= w_bits_next;
      r_cfg_ready <= w_ready_next;
      r_ccff_head <= w_head_next;
      r_ccff_en   <= w_en_next;
      r_cap       <= w_cap_next;
      r_cap_cnt   <= w_cap_cnt_next;
      r_rd_data   <= w_rd_data_next;
      r_rd_valid  <= w_rd_valid_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_aborted   <= w_aborted_next;
    end
  end

  assign o_cfg_ready = r_cfg_ready;
  assign o_ccff_head = r_ccff_head;
  assign o_ccff_en   = r_ccff_en;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_aborted   = r_aborted;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader
//
// Two loaders share the stimulus: u_a (CHAIN_LEN=16) and u_b (CHAIN_LEN=12),
// both WORD_W=8; 'sel' routes start/abort to one of them and selects which
// outputs are observed. Each fabric is modelled as a plain shift register
// fed from head and enabled by ccff_en. Expectations come from the words and
// the preloaded chain value: the head stream is the first CHAIN_LEN bits of
// the concatenated words, the readback is the old chain contents (tail end
// first) cut into 8-bit words, and afterwards the chain holds the new bits.
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     = 1'b1;
  logic        start     = 1'b0;
  logic        abort     = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        sel       = 1'b0;
  logic        pre_req   = 1'b0;
  logic [7:0]  cfg_data  = 8'h00;
  logic [15:0] pre_val   = 16'h0000;

  logic [15:0] chain_a;
  logic [11:0] chain_b;

  logic       a_ready, a_head, a_en, a_rdv, a_busy, a_done, a_abt;
  logic [7:0] a_rdd;
  logic       b_ready, b_head, b_en, b_rdv, b_busy, b_done, b_abt;
  logic [7:0] b_rdd;

  int n_vec = 0;
  int n_err = 0;

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_a (
    .i_prog_clk (clk),
    .i_pReset_n (rst_n),
    .i_start    (start & ~sel),
    .i_abort    (abort & ~sel),
    .i_cfg_data (cfg_data),
    .i_cfg_valid(cfg_valid),
    .o_cfg_ready(a_ready),
    .o_ccff_head(a_head),
    .o_ccff_en  (a_en),
    .i_ccff_tail(chain_a[15]),
    .o_rd_data  (a_rdd),
    .o_rd_valid (a_rdv),
    .o_busy     (a_busy),
    .o_done     (a_done),
    .o_aborted  (a_abt)
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_b (
    .i_prog_clk (clk),
    .i_pReset_n (rst_n),
    .i_start    (start & sel),
    .i_abort    (abort & sel),
    .i_cfg_data (cfg_data),
    .i_cfg_valid(cfg_valid),
    .o_cfg_ready(b_ready),
    .o_ccff_head(b_head),
    .o_ccff_en  (b_en),
    .i_ccff_tail(chain_b[11]),
    .o_rd_data  (b_rdd),
    .o_rd_valid (b_rdv),
    .o_busy     (b_busy),
    .o_done     (b_done),
    .o_aborted  (b_abt)
  );

  logic       m_ready, m_head, m_en, m_rdv, m_busy, m_done, m_abt;
  logic [7:0] m_rdd;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_head  = sel ? b_head  : a_head;
  assign m_en    = sel ? b_en    : a_en;
  assign m_rdv   = sel ? b_rdv   : a_rdv;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_abt   = sel ? b_abt   : a_abt;
  assign m_rdd   = sel ? b_rdd   : a_rdd;

  // Fabric chain models.
  always @(posedge clk) begin
    if (pre_req) begin
      if (sel) chain_b <= pre_val[11:0];
      else     chain_a <= pre_val;
    end else begin
      if (a_en) chain_a <= {chain_a[14:0], a_head};
      if (b_en) chain_b <= {chain_b[10:0], b_head};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One chain load of words w0,w1 after preloading the chain with 'pre'.
  // gap: cycles cfg_valid stays low after the first word is accepted.
  // abort_at / rst_at: abort or async reset once that many enabled shifts
  // have been seen (-1 = never).
  task automatic run(input logic [7:0] w0, input logic [7:0] w1, input logic [15:0] pre,
                     input int gap, input int abort_at, input int rst_at);
    int L, cyc, idx, hs, n_en, first_en, last_en, done_cyc, n_done, since_hs, stall_exp;
    logic [15:0] heads, exp_head, oldsh, mask, chain_now;
    logic [7:0]  rdq[$];
    logic [7:0]  rd0, rd1;
    bit stop, head_moved, quiet;
    L = sel ? 12 : 16;
    cyc = 0; idx = 0; hs = 0; n_en = 0; first_en = -1; last_en = -1;
    done_cyc = -1; n_done = 0; since_hs = 0; heads = '0;
    stop = 0; head_moved = 0;
    mask      = 16'((32'd1 << L) - 32'd1);
    exp_head  = {w0, w1} >> (16 - L);
    oldsh     = pre << (16 - L);
    stall_exp = (gap > 7) ? gap - 7 : 0;

    @(negedge clk);
    pre_val = pre; pre_req = 1'b1;
    @(negedge clk);
    pre_req = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    while (!stop && cyc < 120) begin
      start = 1'b0;
      if (m_en) begin
        heads = {heads[14:0], m_head};
        n_en++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end else if (n_en > 0 && n_en < L && m_head !== heads[0]) begin
        head_moved = 1;
      end
      if (m_rdv) rdq.push_back(m_rdd);
      if (m_done) begin n_done++; done_cyc = cyc; end

      if (m_en && rst_at >= 0 && n_en == rst_at) begin
        cfg_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {m_ready, m_head, m_en, m_rdv, m_busy, m_done, m_abt, m_rdd}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {m_ready, m_en, m_busy, m_done, m_abt}, 0);
        return;
      end

      if (m_en && abort_at >= 0 && n_en == abort_at) begin
        abort = 1'b1; cfg_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_next_cycle", {m_abt, m_en, m_ready, m_busy, m_done}, 5'b10000);
        quiet = 1;
        repeat (4) begin
          @(negedge clk);
          if (m_rdv | m_done | m_en | m_abt | m_busy) quiet = 0;
        end
        chk("abort_quiet_after", quiet, 1);
        chk("abort_no_readback", rdq.size(), 0);
        return;
      end

      if (m_done) begin
        @(negedge clk);
        chk("busy_after_done", {m_busy, m_done, m_en, m_ready}, 0);
        stop = 1;
      end else begin
        start     = (cyc == 4);  // stray start while busy must be ignored
        cfg_valid = !(idx == 1 && since_hs < gap);
        cfg_data  = (idx == 0) ? w0 : (idx == 1) ? w1 : 8'($urandom);
        if (cfg_valid && m_ready) begin
          hs++; idx++; since_hs = 0;
        end else begin
          since_hs++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    cfg_valid = 1'b0;
    start     = 1'b0;

    rd0 = (rdq.size() > 0) ? rdq[0] : 8'h00;
    rd1 = (rdq.size() > 1) ? rdq[1] : 8'h00;
    chain_now = sel ? {4'h0, chain_b} : chain_a;
    chk("done_count", n_done, 1);
    chk("en_cycles", n_en, L);
    chk("head_bits", heads & mask, exp_head);
    chk("handshakes", hs, 2);
    chk("rd_count", rdq.size(), 2);
    chk("rd_word0", rd0, oldsh[15:8]);
    chk("rd_word1", rd1, oldsh[7:0]);
    chk("stall_cycles", (last_en - first_en + 1) - n_en, stall_exp);
    chk("head_hold_in_stall", head_moved, 0);
    chk("done_latency", done_cyc - last_en, 1);
    chk("chain_after", chain_now, exp_head);
    $display("load sel=%0d words=%02h,%02h pre=%04h gap=%0d rd=%02h,%02h", sel, w0, w1, pre, gap, rd0, rd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_a", {a_ready, a_head, a_en, a_rdv, a_busy, a_done, a_abt, a_rdd}, 0);
    chk("reset_b", {b_ready, b_head, b_en, b_rdv, b_busy, b_done, b_abt, b_rdd}, 0);
    rst_n = 1'b1;

    // IDLE ignores cfg_valid and abort; start+abort together: abort wins.
    sel = 1'b0;
    cfg_valid = 1'b1; abort = 1'b1; cfg_data = 8'hFF;
    repeat (3) @(negedge clk);
    chk("idle_ignores_valid_abort", {a_ready, a_en, a_busy, a_abt}, 0);
    cfg_valid = 1'b0; abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_abort_same_cycle", {a_busy, a_abt, a_ready, a_en}, 0);

    // Directed loads on the 16-bit chain.
    run(8'hA5, 8'h3C, 16'hBEEF, 0, -1, -1);
    run(8'h12, 8'h34, 16'hBEEF, 0, -1, -1);
    run(8'h12, 8'h34, 16'hBEEF, 12, -1, -1);

    // Abort after 6 bits, then a full load.
    run(8'hC3, 8'h5A, 16'h1111, 0, 6, -1);
    run(8'h9E, 8'h71, 16'h2468, 0, -1, -1);

    // Async reset mid-load, then the first scenario again.
    run(8'h77, 8'h88, 16'h0F0F, 0, -1, 3);
    run(8'hA5, 8'h3C, 16'hBEEF, 0, -1, -1);

    for (int k = 0; k < 8; k++) begin
      run(8'($urandom), 8'($urandom), 16'($urandom), int'($urandom_range(0, 14)), -1, -1);
    end

    // 12-bit chain: final word truncated, partial readback padded.
    sel = 1'b1;
    run(8'hFF, 8'hF0, 16'h0ABC, 0, -1, -1);
    for (int k = 0; k < 4; k++) begin
      run(8'($urandom), 8'($urandom), 16'($urandom), int'($urandom_range(0, 14)), -1, -1);
    end
    run(8'h5A, 8'hA5, 16'h0F00, 0, 6, -1);
    run(8'hFF, 8'hF0, 16'h0ABC, 9, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
